// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch prefetch front end.
// Width helpers keep the FIFO and the issue logic in agreement on counter sizes.
package if_prefetch_buffer_pkg;

  localparam logic [31:0] NopInst = 32'h0000_0000;

  typedef enum logic [1:0] {
    FifoIdle = 2'b00,
    FifoPop  = 2'b01,
    FifoPush = 2'b10,
    FifoBoth = 2'b11
  } fifoOp_e;

  function automatic int unsigned ptrWidth(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Bundle of ROM-side and ID-side signals of the fetch front end.
// Signal suffixes are relative to the fetch unit (master).
interface if_prefetch_buffer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              stall_i;
  logic              flush_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_data_i, stall_i, flush_i, redirect_pc_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_data_i, stall_i, flush_i, redirect_pc_i
  );
endinterface

// File: rtl/if_prefetch_buffer_fetch_fifo.sv
// DEPTH-entry register FIFO holding {pc, instruction} pairs for the ID stage.
// The head is read straight from storage so ID never sees a ROM-to-ID path.
module if_prefetch_buffer_fetch_fifo
  import if_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [countWidth(DEPTH)-1:0] count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned PtrW = ptrWidth(DEPTH);
  localparam int unsigned CntW = countWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  fifoOp_e          op;

  assign op = fifoOp_e'({push_i, pop_i});

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    case (op)
      FifoPush: begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        count_d = count_q + CntW'(1);
      end
      FifoPop: begin
        rdPtr_d = rdPtr_q + PtrW'(1);
        count_d = count_q - CntW'(1);
      end
      FifoBoth: begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      default: ;
    endcase
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/if_prefetch_buffer.sv
// Fetch front end: PC generator, single in-flight ROM request tracking and a
// prefetch FIFO feeding ID, with ID stall and branch-redirect flush.
module if_prefetch_buffer
  import if_prefetch_buffer_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input logic                  clk,
  input logic                  rst,
  if_prefetch_buffer_if.master bus
);

  localparam int unsigned CntW = countWidth(DEPTH);
  localparam int unsigned OccW = CntW + 1;

  logic [ADDR_W-1:0]        fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0]        inflightPc_q, inflightPc_d;
  logic                     inflight_q, inflight_d;
  logic [CntW-1:0]          count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]        headPc;
  logic [DATA_W-1:0]        headInst;
  logic                     idValid;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [OccW-1:0]          occupancy;

  assign idValid = !rst && (count != '0);
  assign pop     = idValid && !bus.stall_i && !bus.flush_i;
  assign push    = inflight_q && !bus.flush_i;

  // Reserve a slot for the in-flight response so the FIFO can never overflow.
  assign occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
  assign issue     = !rst && !bus.flush_i && (occupancy < OccW'(DEPTH));

  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflightPc_d = inflightPc_q;
    inflight_d   = issue;
    if (bus.flush_i) begin
      fetchPc_d = bus.redirect_pc_i;
    end else if (issue) begin
      inflightPc_d = fetchPc_q;
      fetchPc_d    = fetchPc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q    <= RESET_PC;
      inflightPc_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflightPc_q <= inflightPc_d;
      inflight_q   <= inflight_d;
    end
  end

  if_prefetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (bus.flush_i),
    .wdata_i ({inflightPc_q, bus.rom_data_i}),
    .count_o (count),
    .head_o  (head)
  );

  assign {headPc, headInst} = head;

  assign bus.rom_ce_o   = issue;
  assign bus.rom_addr_o = rst ? '0 : fetchPc_q;
  assign bus.id_valid_o = idValid;
  assign bus.id_pc_o    = idValid ? headPc : '0;
  assign bus.id_inst_o  = idValid ? headInst : DATA_W'(NopInst);

endmodule
